// File: rtl/jigsaw_pkg.sv
// Shared types and constants for the jigsaw host controller:
// arbiter state encoding, opcode values and packet header field positions.
package jigsaw_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_LOCK0,
    ARB_LOCK1
  } arb_state_t;

  localparam int unsigned JIGSAW_AXI_DATA_BITS = 136;

  localparam logic [1:0] OP_DMA_RD   = 2'd0;
  localparam logic [1:0] OP_DMA_WR   = 2'd1;
  localparam logic [1:0] OP_MMIO_RSP = 2'd2;

  localparam int unsigned HDR_OP_LSB   = 0;
  localparam int unsigned HDR_OP_W     = 2;
  localparam int unsigned HDR_TAG_LSB  = 8;
  localparam int unsigned HDR_TAG_W    = 8;
  localparam int unsigned HDR_LEN_LSB  = 16;
  localparam int unsigned HDR_LEN_W    = 16;
  localparam int unsigned HDR_ADDR_LSB = 32;
  localparam int unsigned HDR_ADDR_W   = 64;

  function automatic logic [HDR_OP_W-1:0] hdr_opcode(input logic [127:0] hdr);
    return hdr[HDR_OP_LSB +: HDR_OP_W];
  endfunction

  function automatic logic [HDR_LEN_W-1:0] hdr_length(input logic [127:0] hdr);
    return hdr[HDR_LEN_LSB +: HDR_LEN_W];
  endfunction

endpackage

// File: rtl/jigsaw_axis_skid.sv
// Two-entry AXI4-Stream register slice for data/keep/last/user.
// Both s_ready and m_valid are pure register outputs.
module jigsaw_axis_skid #(
  parameter int unsigned DATA_W = 136,
  parameter int unsigned KEEP_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic [KEEP_W-1:0] s_keep,
  input  logic              s_last,
  input  logic              s_user,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [KEEP_W-1:0] m_keep,
  output logic              m_last,
  output logic              m_user,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              occupied
);

  localparam int unsigned PW = DATA_W + KEEP_W + 2;

  logic [PW-1:0] main_q;
  logic [PW-1:0] skid_q;
  logic          main_vld;
  logic          skid_vld;
  logic [PW-1:0] in_word;
  logic          in_fire;

  assign in_word = {s_data, s_keep, s_last, s_user};
  assign s_ready = ~skid_vld;
  assign in_fire = s_valid & ~skid_vld;

  // The skid entry only fills while the main entry is stalled, so a freed
  // main entry always refills from the skid first to keep beat order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (!main_vld || m_ready) begin
      if (skid_vld) begin
        main_q   <= skid_q;
        main_vld <= 1'b1;
        skid_vld <= 1'b0;
      end else if (in_fire) begin
        main_q   <= in_word;
        main_vld <= 1'b1;
      end else begin
        main_vld <= 1'b0;
      end
    end else if (in_fire) begin
      skid_q   <= in_word;
      skid_vld <= 1'b1;
    end
  end

  assign {m_data, m_keep, m_last, m_user} = main_q;
  assign m_valid  = main_vld;
  assign occupied = main_vld | skid_vld;

endmodule

// File: rtl/jigsaw_net_tx_arbiter.sv
// Packet-atomic 2:1 AXI4-Stream arbiter feeding network_out.
// Define JIGSAW_TX_RR_EN for round-robin; default is fixed priority with anti-starvation.
module jigsaw_net_tx_arbiter
  import jigsaw_pkg::*;
#(
  parameter int unsigned AXI_DATA_BITS = JIGSAW_AXI_DATA_BITS,
  parameter int unsigned KEEP_WIDTH    = AXI_DATA_BITS / 8,
  parameter int unsigned STARVE_LIMIT  = 4,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [AXI_DATA_BITS-1:0] s0_tdata,
  input  logic [KEEP_WIDTH-1:0]    s0_tkeep,
  input  logic                     s0_tvalid,
  input  logic                     s0_tlast,
  input  logic                     s0_tuser,
  output logic                     s0_tready,
  input  logic [AXI_DATA_BITS-1:0] s1_tdata,
  input  logic [KEEP_WIDTH-1:0]    s1_tkeep,
  input  logic                     s1_tvalid,
  input  logic                     s1_tlast,
  input  logic                     s1_tuser,
  output logic                     s1_tready,
  output logic [AXI_DATA_BITS-1:0] m_tdata,
  output logic [KEEP_WIDTH-1:0]    m_tkeep,
  output logic                     m_tvalid,
  output logic                     m_tlast,
  output logic                     m_tuser,
  input  logic                     m_tready,
  output logic [1:0]               grant,
  output logic                     busy,
  output logic [CNT_WIDTH-1:0]     pkt_cnt0,
  output logic [CNT_WIDTH-1:0]     pkt_cnt1
);

  arb_state_t state_q;
  arb_state_t state_d;

  logic                     arb_fire;
  logic                     pick1;
  logic                     slice_ready;
  logic                     slice_occupied;
  logic                     in_valid;
  logic [AXI_DATA_BITS-1:0] in_data;
  logic [KEEP_WIDTH-1:0]    in_keep;
  logic                     in_last;
  logic                     in_user;
  logic                     fire0;
  logic                     fire1;

  assign arb_fire = (state_q == ARB_IDLE) & (s0_tvalid | s1_tvalid);

`ifdef JIGSAW_TX_RR_EN
  logic last1_q;

  // Reset value makes src0 win the very first tie.
  assign pick1 = s1_tvalid & (~s0_tvalid | ~last1_q);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      last1_q <= 1'b1;
    end else if (arb_fire) begin
      last1_q <= pick1;
    end
  end
`else
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_q;
  logic          starved;

  assign starved = (starve_q >= SW'(STARVE_LIMIT));
  assign pick1   = s1_tvalid & (~s0_tvalid | starved);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      starve_q <= '0;
    end else if (arb_fire) begin
      if (pick1) begin
        starve_q <= '0;
      end else if (s1_tvalid && !starved) begin
        starve_q <= starve_q + SW'(1);
      end
    end
  end
`endif

  assign fire0 = (state_q == ARB_LOCK0) & s0_tvalid & slice_ready;
  assign fire1 = (state_q == ARB_LOCK1) & s1_tvalid & slice_ready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (arb_fire) begin
          state_d = pick1 ? ARB_LOCK1 : ARB_LOCK0;
        end
      end
      ARB_LOCK0: begin
        if (fire0 && s0_tlast) begin
          state_d = ARB_IDLE;
        end
      end
      ARB_LOCK1: begin
        if (fire1 && s1_tlast) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    in_valid = 1'b0;
    in_data  = s0_tdata;
    in_keep  = s0_tkeep;
    in_last  = s0_tlast;
    in_user  = s0_tuser;
    if (state_q == ARB_LOCK0) begin
      in_valid = s0_tvalid;
    end else if (state_q == ARB_LOCK1) begin
      in_valid = s1_tvalid;
      in_data  = s1_tdata;
      in_keep  = s1_tkeep;
      in_last  = s1_tlast;
      in_user  = s1_tuser;
    end
  end

  assign s0_tready = (state_q == ARB_LOCK0) & slice_ready;
  assign s1_tready = (state_q == ARB_LOCK1) & slice_ready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else begin
      if (fire0 && s0_tlast) begin
        pkt_cnt0 <= pkt_cnt0 + CNT_WIDTH'(1);
      end
      if (fire1 && s1_tlast) begin
        pkt_cnt1 <= pkt_cnt1 + CNT_WIDTH'(1);
      end
    end
  end

  jigsaw_axis_skid #(
    .DATA_W(AXI_DATA_BITS),
    .KEEP_W(KEEP_WIDTH)
  ) u_skid (
    .clk      (aclk),
    .rst_n    (aresetn),
    .s_data   (in_data),
    .s_keep   (in_keep),
    .s_last   (in_last),
    .s_user   (in_user),
    .s_valid  (in_valid),
    .s_ready  (slice_ready),
    .m_data   (m_tdata),
    .m_keep   (m_tkeep),
    .m_last   (m_tlast),
    .m_user   (m_tuser),
    .m_valid  (m_tvalid),
    .m_ready  (m_tready),
    .occupied (slice_occupied)
  );

  assign grant = {state_q == ARB_LOCK1, state_q == ARB_LOCK0};
  assign busy  = (state_q != ARB_IDLE) | slice_occupied;

endmodule
